// File: rtl/store_write_buffer.sv
// Posted-store FIFO between the core data port and data memory, drained in program order.
// Optional store-to-load forwarding is compiled in when SWB_FORWARD_EN is defined.
module store_write_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic [AW-1:0] DataAdr,
    input  logic [DW-1:0] WriteData,
    output logic          Stall,
    output logic          Empty,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready
`ifdef SWB_FORWARD_EN
    ,
    input  logic [AW-1:0] ReadAdr,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        entry_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          enq;
    logic          deq;

    assign full   = (count_q == CW'(DEPTH));
    assign Empty  = (count_q == CW'(0));
    assign mem_we = ~Empty;
    assign Stall  = MemWrite & full;
    assign enq    = MemWrite & ~full & ~reset;
    assign deq    = mem_we & mem_ready;

    // Head is forced to zero when empty so uncleared storage never leaks X.
    assign mem_addr  = Empty ? '0 : entry_q[rd_ptr_q].addr;
    assign mem_wdata = Empty ? '0 : entry_q[rd_ptr_q].data;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; validity is tracked by count/pointers only.
    always_ff @(posedge clk) begin
        if (enq) begin
            entry_q[wr_ptr_q] <= '{addr: DataAdr, data: WriteData};
        end
    end

`ifdef SWB_FORWARD_EN
    // Walk oldest to youngest so the last match wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) &&
                (entry_q[idx].addr[AW-1:2] == ReadAdr[AW-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_q[idx].data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed self-checking bench for store_write_buffer; define SWB_FORWARD_EN to cover forwarding.
module tb_store_write_buffer;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        Stall;
    logic        Empty;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
`ifdef SWB_FORWARD_EN
    logic [31:0] ReadAdr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    int checks   = 0;
    int failures = 0;

    store_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .Stall     (Stall),
        .Empty     (Empty),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready)
`ifdef SWB_FORWARD_EN
        ,
        .ReadAdr   (ReadAdr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; MemWrite = 1'b1; DataAdr = 32'd96; WriteData = 32'd1; mem_ready = 1'b0;
`ifdef SWB_FORWARD_EN
        ReadAdr = 32'd96;
`endif
        #11;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0b exp=0", mem_we); end
        checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", Empty); end
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", Stall); end
`ifdef SWB_FORWARD_EN
        checks++; if (fwd_hit !== 1'b0) begin failures++; $display("FAIL reset_fwd_hit got=%0b exp=0", fwd_hit); end
`endif
        #11;
        reset = 1'b0; MemWrite = 1'b0;
        cyc();
        checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL post_reset_empty got=%0b exp=1", Empty); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL post_reset_mem_we got=%0b exp=0", mem_we); end
    endtask

    task automatic test_single_store();
        MemWrite = 1'b1; DataAdr = 32'd100; WriteData = 32'd25; mem_ready = 1'b1;
        #3;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%0b exp=0", mem_we); end
        cyc();
        MemWrite = 1'b0;
        #3;
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL single_mem_we got=%0b exp=1", mem_we); end
        checks++; if (mem_addr !== 32'd100) begin failures++; $display("FAIL single_addr got=%0d exp=100", mem_addr); end
        checks++; if (mem_wdata !== 32'd25) begin failures++; $display("FAIL single_data got=%0d exp=25", mem_wdata); end
        cyc();
        checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL single_empty got=%0b exp=1", Empty); end
    endtask

    task automatic test_full_stall();
        logic [31:0] got_a[$];
        logic [31:0] got_d[$];
        logic        accepted;
        mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            MemWrite = 1'b1; DataAdr = 32'(96 + 4 * k); WriteData = 32'(k + 1);
            #3;
            if (k < 4) begin
                checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL full_stall_early k=%0d got=%0b exp=0", k, Stall); end
            end else begin
                checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL full_stall_5th got=%0b exp=1", Stall); end
                checks++; if (mem_addr !== 32'd96) begin failures++; $display("FAIL full_head_hold got=%0d exp=96", mem_addr); end
            end
            if (k < 4) cyc();
        end
        cyc();
        checks++; if (mem_addr !== 32'd96 || mem_wdata !== 32'd1) begin failures++; $display("FAIL full_head_stable got=%0d/%0d exp=96/1", mem_addr, mem_wdata); end
        mem_ready = 1'b1;
        #1;
        checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL full_no_lookahead got=%0b exp=1", Stall); end
        for (int n = 0; n < 20 && (mem_we || MemWrite); n++) begin
            if (mem_we) begin got_a.push_back(mem_addr); got_d.push_back(mem_wdata); end
            accepted = MemWrite & ~Stall;
            cyc();
            if (accepted) MemWrite = 1'b0;
        end
        checks++; if (got_a.size() !== 5) begin failures++; $display("FAIL full_drain_count got=%0d exp=5", got_a.size()); end
        for (int k = 0; k < 5 && k < got_a.size(); k++) begin
            checks++;
            if (got_a[k] !== 32'(96 + 4 * k) || got_d[k] !== 32'(k + 1)) begin
                failures++;
                $display("FAIL full_drain_order k=%0d got=%0d/%0d exp=%0d/%0d", k, got_a[k], got_d[k], 96 + 4 * k, k + 1);
            end
        end
        checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL full_drain_empty got=%0b exp=1", Empty); end
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b0;
        MemWrite = 1'b1; DataAdr = 32'd200; WriteData = 32'd203;
        cyc();
        DataAdr = 32'd204; WriteData = 32'd207;
        cyc();
        mem_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            DataAdr = 32'(208 + 4 * j); WriteData = 32'(211 + 4 * j);
            #1;
            checks++;
            if (Empty !== 1'b0 || Stall !== 1'b0 || mem_addr !== 32'(200 + 4 * j) || mem_wdata !== 32'(203 + 4 * j)) begin
                failures++;
                $display("FAIL b2b_head j=%0d got=%0d/%0d empty=%0b stall=%0b exp=%0d/%0d", j, mem_addr, mem_wdata, Empty, Stall, 200 + 4 * j, 203 + 4 * j);
            end
            cyc();
        end
        MemWrite = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'd248) begin failures++; $display("FAIL b2b_tail0 got=%0b/%0d exp=1/248", mem_we, mem_addr); end
        cyc();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'd252) begin failures++; $display("FAIL b2b_tail1 got=%0b/%0d exp=1/252", mem_we, mem_addr); end
        cyc();
        checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%0b exp=1", Empty); end
    endtask

`ifdef SWB_FORWARD_EN
    task automatic test_forward();
        mem_ready = 1'b0;
        MemWrite = 1'b1; DataAdr = 32'd100; WriteData = 32'd7; ReadAdr = 32'd100;
        #1;
        checks++; if (fwd_hit !== 1'b0) begin failures++; $display("FAIL fwd_same_cycle_empty got=%0b exp=0", fwd_hit); end
        cyc();
        WriteData = 32'd25;
        #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'd7) begin failures++; $display("FAIL fwd_no_enq_bypass got=%0b/%0d exp=1/7", fwd_hit, fwd_data); end
        cyc();
        MemWrite = 1'b0;
        #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'd25) begin failures++; $display("FAIL fwd_youngest got=%0b/%0d exp=1/25", fwd_hit, fwd_data); end
        ReadAdr = 32'd102;
        #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'd25) begin failures++; $display("FAIL fwd_word_match got=%0b/%0d exp=1/25", fwd_hit, fwd_data); end
        ReadAdr = 32'd104;
        #1;
        checks++; if (fwd_hit !== 1'b0) begin failures++; $display("FAIL fwd_miss got=%0b exp=0", fwd_hit); end
        mem_ready = 1'b1;
        cyc();
        cyc();
        checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL fwd_drain_empty got=%0b exp=1", Empty); end
    endtask
`endif

    task automatic test_reset_midflight();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            MemWrite = 1'b1; DataAdr = 32'(300 + 4 * k); WriteData = 32'(k + 9);
            cyc();
        end
        MemWrite = 1'b0;
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL mid_pending got=%0b exp=1", mem_we); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL mid_reset_mem_we got=%0b exp=0", mem_we); end
        checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL mid_reset_empty got=%0b exp=1", Empty); end
        cyc();
        #2;
        reset = 1'b0;
        mem_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            cyc();
            checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL mid_after_release n=%0d got=%0b exp=0", n, mem_we); end
        end
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_full_stall();
        test_back_to_back();
`ifdef SWB_FORWARD_EN
        test_forward();
`endif
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
